// File: rtl/window_gen_3x3.sv
`default_nettype none
// ============================================================================
// Module      : window_gen_3x3
// Description : Streaming 3x3 window generator over a raster pixel stream,
//               two line buffers, valid-only windows (no padding).
// Revision    : 1.0 - initial release
// ============================================================================
module window_gen_3x3 #(
    parameter int DATA_W = 32,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sof,
    input  logic              pix_valid,
    input  logic [DATA_W-1:0] pix_in,
    output logic              win_valid,
    output logic [DATA_W-1:0] win_0,
    output logic [DATA_W-1:0] win_1,
    output logic [DATA_W-1:0] win_2,
    output logic [DATA_W-1:0] win_3,
    output logic [DATA_W-1:0] win_4,
    output logic [DATA_W-1:0] win_5,
    output logic [DATA_W-1:0] win_6,
    output logic [DATA_W-1:0] win_7,
    output logic [DATA_W-1:0] win_8,
    output logic              frame_done
);

    localparam int c_COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int c_ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(IMG_W - 1);
    localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(IMG_H - 1);
    localparam logic [c_COL_W-1:0] c_COL_TWO  = c_COL_W'(2);
    localparam logic [c_ROW_W-1:0] c_ROW_TWO  = c_ROW_W'(2);
    localparam logic [c_COL_W-1:0] c_COL_ONE  = c_COL_W'(1);
    localparam logic [c_ROW_W-1:0] c_ROW_ONE  = c_ROW_W'(1);

    logic [c_COL_W-1:0] r_col;
    logic [c_ROW_W-1:0] r_row;
    logic [c_COL_W-1:0] w_col_eff;
    logic [c_ROW_W-1:0] w_row_eff;
    logic               w_col_last;
    logic               w_row_last;
    logic               w_win_ok;

    logic [DATA_W-1:0]  r_lb0 [IMG_W];
    logic [DATA_W-1:0]  r_lb1 [IMG_W];
    logic [DATA_W-1:0]  w_lb0_rd;
    logic [DATA_W-1:0]  w_lb1_rd;

    logic [DATA_W-1:0]  r_sh      [9];
    logic [DATA_W-1:0]  w_sh_next [9];
    logic [DATA_W-1:0]  r_out     [9];
    logic               r_win_valid;
    logic               r_frame_done;

    // sof forces the current pixel to position (0,0) regardless of the counters
    assign w_col_eff  = sof ? '0 : r_col;
    assign w_row_eff  = sof ? '0 : r_row;
    assign w_col_last = (w_col_eff == c_COL_LAST);
    assign w_row_last = (w_row_eff == c_ROW_LAST);
    assign w_win_ok   = (w_row_eff >= c_ROW_TWO) && (w_col_eff >= c_COL_TWO);

    assign w_lb0_rd = r_lb0[w_col_eff];
    assign w_lb1_rd = r_lb1[w_col_eff];

    always_ff @(posedge clk) begin
        if (pix_valid) begin
            r_lb1[w_col_eff] <= w_lb0_rd;
            r_lb0[w_col_eff] <= pix_in;
        end
    end

    for (genvar gr = 0; gr < 3; gr++) begin : g_shift
        assign w_sh_next[gr*3 + 0] = r_sh[gr*3 + 1];
        assign w_sh_next[gr*3 + 1] = r_sh[gr*3 + 2];
    end
    assign w_sh_next[2] = w_lb1_rd;
    assign w_sh_next[5] = w_lb0_rd;
    assign w_sh_next[8] = pix_in;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (pix_valid) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : (w_row_eff + c_ROW_ONE);
            end else begin
                r_col <= w_col_eff + c_COL_ONE;
                r_row <= w_row_eff;
            end
        end else if (sof) begin
            r_col <= '0;
            r_row <= '0;
        end
    end

    // The shift register moves on every accepted pixel; the visible taps only
    // update when the shifted contents form a complete in-image window.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_win_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            for (int k = 0; k < 9; k++) begin
                r_sh[k]  <= '0;
                r_out[k] <= '0;
            end
        end else begin
            r_win_valid  <= pix_valid && w_win_ok;
            r_frame_done <= pix_valid && w_col_last && w_row_last;
            if (pix_valid) begin
                for (int k = 0; k < 9; k++) begin
                    r_sh[k] <= w_sh_next[k];
                end
                if (w_win_ok) begin
                    for (int k = 0; k < 9; k++) begin
                        r_out[k] <= w_sh_next[k];
                    end
                end
            end
        end
    end

    assign win_valid  = r_win_valid;
    assign frame_done = r_frame_done;
    assign win_0      = r_out[0];
    assign win_1      = r_out[1];
    assign win_2      = r_out[2];
    assign win_3      = r_out[3];
    assign win_4      = r_out[4];
    assign win_5      = r_out[5];
    assign win_6      = r_out[6];
    assign win_7      = r_out[7];
    assign win_8      = r_out[8];

endmodule
`default_nettype wire

// File: tb/tb_window_gen_3x3.sv
`default_nettype none
// ============================================================================
// Module      : tb_window_gen_3x3
// Description : Self-checking bench for window_gen_3x3 (4x4 and 5x3 instances)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_window_gen_3x3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sof_a = 1'b0, pv_a = 1'b0;
    logic        sof_b = 1'b0, pv_b = 1'b0;
    logic [31:0] pix_a = '0, pix_b = '0;
    logic        wv_a, fd_a, wv_b, fd_b;
    logic [31:0] win_a [9];
    logic [31:0] win_b [9];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    window_gen_3x3 #(.DATA_W(32), .IMG_W(4), .IMG_H(4)) u_dut_a (
        .clk(clk), .rst(rst), .sof(sof_a), .pix_valid(pv_a), .pix_in(pix_a),
        .win_valid(wv_a),
        .win_0(win_a[0]), .win_1(win_a[1]), .win_2(win_a[2]),
        .win_3(win_a[3]), .win_4(win_a[4]), .win_5(win_a[5]),
        .win_6(win_a[6]), .win_7(win_a[7]), .win_8(win_a[8]),
        .frame_done(fd_a)
    );

    window_gen_3x3 #(.DATA_W(32), .IMG_W(5), .IMG_H(3)) u_dut_b (
        .clk(clk), .rst(rst), .sof(sof_b), .pix_valid(pv_b), .pix_in(pix_b),
        .win_valid(wv_b),
        .win_0(win_b[0]), .win_1(win_b[1]), .win_2(win_b[2]),
        .win_3(win_b[3]), .win_4(win_b[4]), .win_5(win_b[5]),
        .win_6(win_b[6]), .win_7(win_b[7]), .win_8(win_b[8]),
        .frame_done(fd_b)
    );

    // Model: the frame as an image array; a window is simply img[r-2..r][c-2..c]
    logic [31:0] img     [2][5][5];
    int          mrow    [2];
    int          mcol    [2];
    logic        exp_wv  [2];
    logic        exp_fd  [2];
    logic [31:0] exp_win [2][9];

    logic [31:0] wins_a [$];
    logic [31:0] wins_b [$];
    int          cofd_a = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset(input int d);
        mrow[d] = 0;
        mcol[d] = 0;
        exp_wv[d] = 1'b0;
        exp_fd[d] = 1'b0;
        for (int k = 0; k < 9; k++) exp_win[d][k] = '0;
    endtask

    task automatic model_step(input int d, input int w, input int h,
                              input logic v, input logic s, input logic [31:0] p);
        int r, c;
        exp_wv[d] = 1'b0;
        exp_fd[d] = 1'b0;
        if (v) begin
            r = s ? 0 : mrow[d];
            c = s ? 0 : mcol[d];
            img[d][r][c] = p;
            if (r >= 2 && c >= 2) begin
                exp_wv[d] = 1'b1;
                for (int k = 0; k < 9; k++)
                    exp_win[d][k] = img[d][r - 2 + k / 3][c - 2 + k % 3];
            end
            if (r == h - 1 && c == w - 1) exp_fd[d] = 1'b1;
            c++;
            if (c == w) begin
                c = 0;
                r++;
                if (r == h) r = 0;
            end
            mrow[d] = r;
            mcol[d] = c;
        end else if (s) begin
            mrow[d] = 0;
            mcol[d] = 0;
        end
    endtask

    task automatic step(input logic va, input logic sa, input logic [31:0] pa,
                        input logic vb, input logic sb, input logic [31:0] pb);
        @(negedge clk);
        pv_a = va; sof_a = sa; pix_a = pa;
        pv_b = vb; sof_b = sb; pix_b = pb;
        model_step(0, 4, 4, va, sa, pa);
        model_step(1, 5, 3, vb, sb, pb);
    endtask

    task automatic a_pix(input logic s, input logic [31:0] p);
        step(1'b1, s, p, 1'b0, 1'b0, '0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    endtask

    task automatic chk_win(input string name, input int which, input int idx,
                           input logic [31:0] e [9]);
        for (int k = 0; k < 9; k++) begin
            if (which == 0) chk($sformatf("%s_tap%0d", name, k), wins_a[idx * 9 + k], e[k]);
            else            chk($sformatf("%s_tap%0d", name, k), wins_b[idx * 9 + k], e[k]);
        end
    endtask

    // Per-cycle compare against the model, sampled 1 time unit after the edge
    always @(posedge clk) begin
        #1;
        chk("a_win_valid", {31'b0, wv_a}, {31'b0, exp_wv[0]});
        chk("a_frame_done", {31'b0, fd_a}, {31'b0, exp_fd[0]});
        chk("b_win_valid", {31'b0, wv_b}, {31'b0, exp_wv[1]});
        chk("b_frame_done", {31'b0, fd_b}, {31'b0, exp_fd[1]});
        for (int k = 0; k < 9; k++) begin
            chk($sformatf("a_win_%0d", k), win_a[k], exp_win[0][k]);
            chk($sformatf("b_win_%0d", k), win_b[k], exp_win[1][k]);
        end
        if (wv_a) begin
            for (int k = 0; k < 9; k++) wins_a.push_back(win_a[k]);
            if (fd_a) cofd_a++;
        end
        if (wv_b) for (int k = 0; k < 9; k++) wins_b.push_back(win_b[k]);
    end

    initial begin
        logic [31:0] e_first [9];
        logic [31:0] e_last  [9];
        logic [31:0] e [9];
        int n0, c0;

        e_first = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
        e_last  = '{6, 7, 8, 10, 11, 12, 14, 15, 16};
        model_reset(0);
        model_reset(1);
        idle(3);
        @(negedge clk);
        rst = 1'b1;
        idle(2);

        // T1: continuous stream
        n0 = wins_a.size() / 9;
        for (int i = 1; i <= 16; i++) a_pix(1'b0, i);
        idle(2);
        chk("t1_count", wins_a.size() / 9 - n0, 4);
        chk_win("t1_first", 0, n0, e_first);
        chk_win("t1_last", 0, n0 + 3, e_last);

        // T2: pix_valid toggling
        n0 = wins_a.size() / 9;
        for (int i = 1; i <= 16; i++) begin
            a_pix(1'b0, i);
            idle(1);
        end
        idle(1);
        chk("t2_count", wins_a.size() / 9 - n0, 4);
        chk_win("t2_first", 0, n0, e_first);
        chk_win("t2_last", 0, n0 + 3, e_last);

        // T3: two back-to-back frames
        n0 = wins_a.size() / 9;
        c0 = cofd_a;
        for (int i = 1; i <= 16; i++) a_pix(i == 1, i);
        for (int i = 101; i <= 116; i++) a_pix(1'b0, i);
        idle(2);
        chk("t3_count", wins_a.size() / 9 - n0, 8);
        chk("t3_fd_with_win", cofd_a - c0, 2);
        e = '{101, 102, 103, 105, 106, 107, 109, 110, 111};
        chk_win("t3_fifth", 0, n0 + 4, e);

        // T4: reset mid-frame, then restart
        for (int i = 1; i <= 9; i++) a_pix(1'b0, i);
        @(negedge clk);
        pv_a = 1'b0;
        rst = 1'b0;
        model_reset(0);
        model_reset(1);
        #1;
        chk("t4_rst_win_valid", {31'b0, wv_a}, 32'd0);
        for (int k = 0; k < 9; k++) chk($sformatf("t4_rst_win_%0d", k), win_a[k], 32'd0);
        idle(2);
        @(negedge clk);
        rst = 1'b1;
        n0 = wins_a.size() / 9;
        for (int i = 1; i <= 16; i++) a_pix(1'b0, i);
        idle(2);
        chk("t4_count", wins_a.size() / 9 - n0, 4);
        chk_win("t4_first", 0, n0, e_first);
        chk_win("t4_last", 0, n0 + 3, e_last);

        // T5: sof with pixel 6 mid-frame
        for (int i = 1; i <= 5; i++) a_pix(1'b0, i);
        n0 = wins_a.size() / 9;
        for (int i = 6; i <= 15; i++) a_pix(i == 6, i);
        idle(1);
        chk("t5_none_before_11th", wins_a.size() / 9 - n0, 0);
        a_pix(1'b0, 16);
        idle(1);
        chk("t5_count", wins_a.size() / 9 - n0, 1);
        e = '{6, 7, 8, 10, 11, 12, 14, 15, 16};
        chk_win("t5_window", 0, n0, e);

        // sof without a pixel realigns the counters
        step(1'b0, 1'b1, '0, 1'b0, 1'b0, '0);
        n0 = wins_a.size() / 9;
        for (int i = 1; i <= 16; i++) a_pix(1'b0, i);
        idle(2);
        chk("t5b_count", wins_a.size() / 9 - n0, 4);
        chk_win("t5b_first", 0, n0, e_first);

        // T6: 5x3 instance
        n0 = wins_b.size() / 9;
        for (int i = 1; i <= 15; i++) step(1'b0, 1'b0, '0, 1'b1, 1'b0, i);
        idle(2);
        chk("t6_count", wins_b.size() / 9 - n0, 3);
        e = '{1, 2, 3, 6, 7, 8, 11, 12, 13};
        chk_win("t6_first", 1, n0, e);
        e = '{3, 4, 5, 8, 9, 10, 13, 14, 15};
        chk_win("t6_last", 1, n0 + 2, e);

        idle(1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
